// File: rtl/conv5x5_pe_if.sv
// Bus bundle between the 5x5 line buffer / coefficient loader and conv5x5_pe.
// master drives windows and coefficients; slave is the processing element.
interface conv5x5_pe_if #(
  parameter int DATA_BITS = 8,
  parameter int BIAS_BITS = 16,
  parameter int OUT_BITS  = 8
);
  logic [25*DATA_BITS-1:0] window_in;
  logic                    window_valid;
  logic                    wt_load_start;
  logic                    wt_wr_en;
  logic [BIAS_BITS-1:0]    wt_wr_data;
  logic                    weights_ready;
  logic [OUT_BITS-1:0]     out_data;
  logic                    out_valid;

  modport master (
    output window_in, window_valid, wt_load_start, wt_wr_en, wt_wr_data,
    input  weights_ready, out_data, out_valid
  );

  modport slave (
    input  window_in, window_valid, wt_load_start, wt_wr_en, wt_wr_data,
    output weights_ready, out_data, out_valid
  );
endinterface

// File: rtl/conv5x5_pe.sv
// 5x5 single-channel convolution PE: serial coefficient load, 4-stage MAC pipeline,
// shift + saturate. Define CONV_RELU_EN for ReLU (unsigned) output, else signed saturation.
module conv5x5_pe #(
  parameter int DATA_BITS   = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int BIAS_BITS   = 16,
  parameter int SHIFT       = 7,
  parameter int OUT_BITS    = 8
) (
  input  logic         clk,
  input  logic         rst,
  conv5x5_pe_if.slave  bus
);
  localparam int ACC_BITS  = DATA_BITS + WEIGHT_BITS + 6;
  localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS + 1;
  localparam int TAPS      = 25;
  localparam int ROWS      = 5;
  localparam logic [4:0] BIAS_IDX = 5'(TAPS);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t     state_reg, state_next;
  logic [4:0] index_reg;
  logic       load_active;
  logic       wr_accept;
  logic       win_accept;
  logic       weights_ready_c;

  logic signed [WEIGHT_BITS-1:0] coef_reg [TAPS];
  logic signed [BIAS_BITS-1:0]   bias_reg;

  logic [TAPS*PROD_BITS-1:0] prod_next, prod_reg;
  logic [TAPS*ACC_BITS-1:0]  prod_ext;
  logic [ROWS*ACC_BITS-1:0]  row_next, row_reg;
  logic signed [ACC_BITS-1:0] acc_next, acc_reg;
  logic signed [ACC_BITS-1:0] shifted;
  logic [OUT_BITS-1:0]        sat_next, out_data_reg;
  logic v1_reg, v2_reg, v3_reg, out_valid_reg;

  // ---------------- load FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.wt_load_start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD:    if (bus.wt_wr_en && index_reg == BIAS_IDX) state_next = READY;
        default: ;
      endcase
    end
  end

  // A simultaneous start always wins over a write or a window.
  always_comb begin
    load_active     = (state_reg == LOAD);
    weights_ready_c = (state_reg == READY);
    wr_accept       = load_active && bus.wt_wr_en && !bus.wt_load_start;
    win_accept      = weights_ready_c && bus.window_valid && !bus.wt_load_start;
  end

  // ---------------- coefficient store ----------------
  always_ff @(posedge clk) begin
    if (rst || bus.wt_load_start) begin
      index_reg <= '0;
    end else if (wr_accept) begin
      index_reg <= index_reg + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_reg[i] <= '0;
      bias_reg <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < TAPS; i++) begin
        if (index_reg == 5'(i)) coef_reg[i] <= $signed(bus.wt_wr_data[WEIGHT_BITS-1:0]);
      end
      if (index_reg == BIAS_IDX) bias_reg <= $signed(bus.wt_wr_data);
    end
  end

  // ---------------- S1: products (pixel zero-extended, weight sign-extended) ----------------
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [PROD_BITS-1:0] pix_x, wt_x, prod_c;
      assign pix_x  = {{(PROD_BITS-DATA_BITS){1'b0}}, bus.window_in[gi*DATA_BITS +: DATA_BITS]};
      assign wt_x   = {{(PROD_BITS-WEIGHT_BITS){coef_reg[gi][WEIGHT_BITS-1]}}, coef_reg[gi]};
      assign prod_c = pix_x * wt_x;
      assign prod_next[gi*PROD_BITS +: PROD_BITS] = prod_c;
      assign prod_ext[gi*ACC_BITS +: ACC_BITS] =
        {{(ACC_BITS-PROD_BITS){prod_reg[gi*PROD_BITS+PROD_BITS-1]}},
         prod_reg[gi*PROD_BITS +: PROD_BITS]};
    end
  endgenerate

  // ---------------- S2: row sums ----------------
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [ACC_BITS-1:0] row_c;
      always_comb begin
        row_c = '0;
        for (int c = 0; c < ROWS; c++) begin
          row_c = row_c + prod_ext[(gi*ROWS+c)*ACC_BITS +: ACC_BITS];
        end
      end
      assign row_next[gi*ACC_BITS +: ACC_BITS] = row_c;
    end
  endgenerate

  // ---------------- S3: total plus bias ----------------
  always_comb begin
    acc_next = {{(ACC_BITS-BIAS_BITS){bias_reg[BIAS_BITS-1]}}, bias_reg};
    for (int r = 0; r < ROWS; r++) begin
      acc_next = acc_next + row_reg[r*ACC_BITS +: ACC_BITS];
    end
  end

  // ---------------- S4: shift, activation, saturation ----------------
  assign shifted = acc_reg >>> SHIFT;

`ifdef CONV_RELU_EN
  localparam logic signed [ACC_BITS-1:0] UMAX = ACC_BITS'((1 << OUT_BITS) - 1);
  always_comb begin
    sat_next = '0;
    if (shifted < 0)         sat_next = '0;
    else if (shifted > UMAX) sat_next = '1;
    else                     sat_next = shifted[OUT_BITS-1:0];
  end
`else
  localparam logic signed [ACC_BITS-1:0] SMAX = ACC_BITS'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SMIN = -(ACC_BITS'(1 << (OUT_BITS-1)));
  always_comb begin
    sat_next = '0;
    if (shifted > SMAX)      sat_next = {1'b0, {(OUT_BITS-1){1'b1}}};
    else if (shifted < SMIN) sat_next = {1'b1, {(OUT_BITS-1){1'b0}}};
    else                     sat_next = shifted[OUT_BITS-1:0];
  end
`endif

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    prod_reg <= prod_next;
    row_reg  <= row_next;
    acc_reg  <= acc_next;
  end

  // A reload discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst || bus.wt_load_start) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      v3_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      v1_reg        <= win_accept;
      v2_reg        <= v1_reg;
      v3_reg        <= v2_reg;
      out_valid_reg <= v3_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
    end else if (v3_reg) begin
      out_data_reg <= sat_next;
    end
  end

  assign bus.weights_ready = weights_ready_c;
  assign bus.out_data      = out_data_reg;
  assign bus.out_valid     = out_valid_reg;
endmodule
